// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM states and
// instruction field positions.
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'h0,
      OP_SUB  = 4'h1,
      OP_MUL  = 4'h2,
      OP_ORR  = 4'h3,
      OP_AND  = 4'h4,
      OP_EOR  = 4'h5,
      OP_LSL  = 4'h6,
      OP_LSR  = 4'h7,
      OP_ROR  = 4'h8,
      OP_MOV  = 4'h9,
      OP_LDR  = 4'hA,
      OP_CMP  = 4'hB,
      OP_NOP  = 4'hC,
      OP_B    = 4'hD,
      OP_BEQ  = 4'hE,
      OP_HALT = 4'hF
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXECUTE,
      ST_WRITEBACK,
      ST_HALTED
   } state_e;

   localparam int unsigned OPC_MSB = 31;
   localparam int unsigned OPC_LSB = 28;
   localparam int unsigned S_BIT   = 27;
   localparam int unsigned RD_MSB  = 26;
   localparam int unsigned RD_LSB  = 23;
   localparam int unsigned RN_MSB  = 22;
   localparam int unsigned RN_LSB  = 19;
   localparam int unsigned RM_MSB  = 18;
   localparam int unsigned RM_LSB  = 15;
   localparam int unsigned IMM_MSB = 14;
   localparam int unsigned IMM_LSB = 0;

   // Bit index of Z within the NZCV nibble
   localparam int unsigned FLAG_Z  = 2;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode classifier for the ALU sequencer.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [3:0] opcode,
   input  logic       s_bit,
   output logic       writes_reg,
   output logic       sets_flags,
   output logic       is_branch,
   output logic       is_cond,
   output logic       is_halt
);

   always_comb begin
      writes_reg = (opcode <= OP_LDR);
      // Data ops only update flags when S is set; CMP always does
      sets_flags = (s_bit && (opcode <= OP_MOV)) || (opcode == OP_CMP);
      is_branch  = (opcode == OP_B) || (opcode == OP_BEQ);
      is_cond    = (opcode == OP_BEQ);
      is_halt    = (opcode == OP_HALT);
   end

endmodule

// File: rtl/alu_sequencer.sv
// Four-phase instruction sequencer (fetch/decode/execute/writeback) that
// drives an external ALU, flag generator and register file.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned PC_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] instr_data,
   input  logic [3:0]            alu_flags,
   output logic [PC_WIDTH-1:0]   pc,
   output logic                  mem_rd,
   output logic [3:0]            alu_opcode,
   output logic [3:0]            rd_addr,
   output logic [3:0]            rn_addr,
   output logic [3:0]            rm_addr,
   output logic [DATA_WIDTH-1:0] imm,
   output logic                  wr_en,
   output logic [3:0]            flags,
   output logic                  busy,
   output logic                  halted
);

   state_e                  state_q, state_d;
   logic [PC_WIDTH-1:0]     pc_q, pc_d;
   logic [3:0]              flags_q, flags_d;
   logic [DATA_WIDTH-1:0]   ir_q, ir_d;

   logic [3:0]              dec_opcode;
   logic                    dec_s_bit;
   logic                    writes_reg, sets_flags, is_branch, is_cond, is_halt;
   logic                    exec_phase;
   logic [PC_WIDTH-1:0]     branch_target;

   // In DECODE the word is still on instr_data; afterwards it lives in ir_q
   always_comb begin
      if (state_q == ST_DECODE) begin
         dec_opcode = instr_data[OPC_MSB:OPC_LSB];
         dec_s_bit  = instr_data[S_BIT];
      end else begin
         dec_opcode = ir_q[OPC_MSB:OPC_LSB];
         dec_s_bit  = ir_q[S_BIT];
      end
   end

   alu_seq_decode u_decode (
      .opcode     (dec_opcode),
      .s_bit      (dec_s_bit),
      .writes_reg (writes_reg),
      .sets_flags (sets_flags),
      .is_branch  (is_branch),
      .is_cond    (is_cond),
      .is_halt    (is_halt)
   );

   assign branch_target = PC_WIDTH'(ir_q[IMM_MSB:IMM_LSB]);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      flags_d = flags_q;
      ir_d    = ir_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_FETCH;
               pc_d    = '0;
            end
         end
         ST_FETCH: begin
            state_d = ST_DECODE;
         end
         ST_DECODE: begin
            ir_d    = instr_data;
            state_d = is_halt ? ST_HALTED : ST_EXECUTE;
         end
         ST_EXECUTE: begin
            state_d = ST_WRITEBACK;
         end
         ST_WRITEBACK: begin
            state_d = ST_FETCH;
            if (sets_flags) begin
               flags_d = alu_flags;
            end
            // BEQ tests Z as it stood before this writeback's flag load
            if (is_branch && (!is_cond || flags_q[FLAG_Z])) begin
               pc_d = branch_target;
            end else begin
               pc_d = pc_q + PC_WIDTH'(1);
            end
         end
         ST_HALTED: begin
            state_d = ST_HALTED;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         flags_q <= '0;
         ir_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         flags_q <= flags_d;
         ir_q    <= ir_d;
      end
   end

   assign exec_phase = (state_q == ST_EXECUTE) || (state_q == ST_WRITEBACK);

   always_comb begin
      pc         = pc_q;
      flags      = flags_q;
      mem_rd     = (state_q == ST_FETCH);
      wr_en      = (state_q == ST_WRITEBACK) && writes_reg;
      busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) || exec_phase;
      halted     = (state_q == ST_HALTED);
      alu_opcode = '0;
      rd_addr    = '0;
      rn_addr    = '0;
      rm_addr    = '0;
      imm        = '0;
      if (exec_phase) begin
         alu_opcode = ir_q[OPC_MSB:OPC_LSB];
         rd_addr    = ir_q[RD_MSB:RD_LSB];
         rn_addr    = ir_q[RN_MSB:RN_LSB];
         rm_addr    = ir_q[RM_MSB:RM_LSB];
         imm        = DATA_WIDTH'(ir_q[IMM_MSB:IMM_LSB]);
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a one-cycle-latency instruction memory.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] instr_data = '0;
   logic [3:0]  alu_flags = '0;
   logic [7:0]  pc;
   logic        mem_rd;
   logic [3:0]  alu_opcode, rd_addr, rn_addr, rm_addr;
   logic [31:0] imm;
   logic        wr_en;
   logic [3:0]  flags;
   logic        busy, halted;

   logic [31:0] mem [256];
   int          n_checks = 0;
   int          n_pass = 0;

   alu_sequencer #(.PC_WIDTH(8), .DATA_WIDTH(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .instr_data (instr_data),
      .alu_flags  (alu_flags),
      .pc         (pc),
      .mem_rd     (mem_rd),
      .alu_opcode (alu_opcode),
      .rd_addr    (rd_addr),
      .rn_addr    (rn_addr),
      .rm_addr    (rm_addr),
      .imm        (imm),
      .wr_en      (wr_en),
      .flags      (flags),
      .busy       (busy),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_rd) instr_data <= mem[pc];
   end

   function automatic logic [31:0] enc(input logic [3:0] op, input logic s,
                                       input logic [3:0] rd, input logic [3:0] rn,
                                       input logic [3:0] rm, input logic [14:0] im);
      return {op, s, rd, rn, rm, im};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0;
      tick(); tick();
      reset = 1'b0;
      n_checks++; if (pc !== 8'h00) $display("FAIL reset_pc got %h exp 00", pc); else n_pass++;
      n_checks++; if ({busy, halted, mem_rd, wr_en} !== 4'b0000) $display("FAIL reset_ctl got %b exp 0000", {busy, halted, mem_rd, wr_en}); else n_pass++;
      n_checks++; if (flags !== 4'h0) $display("FAIL reset_flags got %h exp 0", flags); else n_pass++;
      n_checks++; if ({alu_opcode, rd_addr, imm} !== 40'h0) $display("FAIL reset_fields got %h exp 0", {alu_opcode, rd_addr, imm}); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL idle_hold got busy=%b exp 0", busy); else n_pass++;
   endtask

   task automatic test_add();
      alu_flags = 4'hF;
      start = 1'b1; tick(); start = 1'b0;
      n_checks++; if ({mem_rd, busy} !== 2'b11) $display("FAIL add_fetch got mem_rd,busy=%b exp 11", {mem_rd, busy}); else n_pass++;
      n_checks++; if (rd_addr !== 4'h0) $display("FAIL add_fetch_rd got %h exp 0", rd_addr); else n_pass++;
      tick();
      n_checks++; if (mem_rd !== 1'b0) $display("FAIL add_decode_mem_rd got %b exp 0", mem_rd); else n_pass++;
      tick();
      n_checks++; if ({alu_opcode, rd_addr, rn_addr, rm_addr} !== 16'h0123) $display("FAIL add_exec_fields got %h exp 0123", {alu_opcode, rd_addr, rn_addr, rm_addr}); else n_pass++;
      n_checks++; if (wr_en !== 1'b0) $display("FAIL add_exec_wr_en got %b exp 0", wr_en); else n_pass++;
      tick();
      n_checks++; if ({wr_en, rd_addr} !== 5'b1_0001) $display("FAIL add_wb got wr_en,rd=%b exp 10001", {wr_en, rd_addr}); else n_pass++;
      tick();
      n_checks++; if (pc !== 8'h01) $display("FAIL add_next_pc got %h exp 01", pc); else n_pass++;
      n_checks++; if (flags !== 4'h0) $display("FAIL add_flags got %h exp 0", flags); else n_pass++;
      n_checks++; if ({wr_en, mem_rd} !== 2'b01) $display("FAIL add_refetch got wr_en,mem_rd=%b exp 01", {wr_en, mem_rd}); else n_pass++;
   endtask

   task automatic test_sub_beq();
      alu_flags = 4'b0100;
      tick(); tick();
      n_checks++; if ({alu_opcode, rd_addr} !== 8'h14) $display("FAIL sub_exec got %h exp 14", {alu_opcode, rd_addr}); else n_pass++;
      n_checks++; if (imm !== 32'h0000_0123) $display("FAIL sub_imm got %h exp 00000123", imm); else n_pass++;
      tick();
      n_checks++; if (wr_en !== 1'b1) $display("FAIL sub_wb got wr_en=%b exp 1", wr_en); else n_pass++;
      tick();
      n_checks++; if ({pc, flags} !== 12'h02_4) $display("FAIL sub_after got pc,flags=%h exp 024", {pc, flags}); else n_pass++;
      alu_flags = 4'b0000;
      tick(); tick();
      n_checks++; if ({alu_opcode, imm} !== 36'hE_0000_0020) $display("FAIL beq_exec got %h exp E00000020", {alu_opcode, imm}); else n_pass++;
      tick();
      n_checks++; if (wr_en !== 1'b0) $display("FAIL beq_wb got wr_en=%b exp 0", wr_en); else n_pass++;
      tick();
      n_checks++; if ({pc, flags} !== 12'h20_4) $display("FAIL beq_taken got pc,flags=%h exp 204", {pc, flags}); else n_pass++;
   endtask

   task automatic test_cmp();
      logic seen;
      alu_flags = 4'b1000;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wr_en === 1'b1) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL cmp_wr_en got seen=%b exp 0", seen); else n_pass++;
      n_checks++; if ({pc, flags} !== 12'h21_8) $display("FAIL cmp_after got pc,flags=%h exp 218", {pc, flags}); else n_pass++;
      alu_flags = 4'b0100;
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if ({pc, flags} !== 12'h22_8) $display("FAIL beq_not_taken got pc,flags=%h exp 228", {pc, flags}); else n_pass++;
   endtask

   task automatic test_wrap();
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (pc !== 8'hFF) $display("FAIL b_to_ff got %h exp FF", pc); else n_pass++;
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if ({pc, mem_rd} !== 9'h0_01) $display("FAIL nop_wrap got pc,mem_rd=%h exp 001", {pc, mem_rd}); else n_pass++;
      reset = 1'b1; tick(); reset = 1'b0;
   endtask

   task automatic test_halt();
      int bad;
      mem[0] = enc(4'hD, 1'b0, 4'h0, 4'h0, 4'h0, 15'h0005);
      mem[5] = enc(4'hF, 1'b0, 4'h0, 4'h0, 4'h0, 15'h0000);
      start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      n_checks++; if (pc !== 8'h05) $display("FAIL halt_fetch_pc got %h exp 05", pc); else n_pass++;
      tick(); tick();
      n_checks++; if ({halted, busy, pc} !== 10'b10_0000_0101) $display("FAIL halt_enter got halted,busy,pc=%b exp 1000000101", {halted, busy, pc}); else n_pass++;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         start = i[0];
         tick();
         if (halted !== 1'b1 || busy !== 1'b0 || pc !== 8'h05 || wr_en !== 1'b0 || mem_rd !== 1'b0) bad++;
      end
      start = 1'b0;
      n_checks++; if (bad !== 0) $display("FAIL halt_persist got %0d bad cycles exp 0", bad); else n_pass++;
      reset = 1'b1; tick(); reset = 1'b0;
      n_checks++; if ({halted, busy, pc} !== 10'b00_0000_0000) $display("FAIL halt_reset got halted,busy,pc=%b exp 0", {halted, busy, pc}); else n_pass++;
   endtask

   task automatic test_reset_exec();
      mem[0] = enc(4'hD, 1'b0, 4'h0, 4'h0, 4'h0, 15'h0040);
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      n_checks++; if ({alu_opcode, imm} !== 36'hD_0000_0040) $display("FAIL rst_exec_fields got %h exp D00000040", {alu_opcode, imm}); else n_pass++;
      reset = 1'b1; tick(); reset = 1'b0;
      n_checks++; if ({busy, wr_en, pc} !== 10'h000) $display("FAIL rst_exec_after got busy,wr_en,pc=%h exp 000", {busy, wr_en, pc}); else n_pass++;
      tick(); tick();
      n_checks++; if ({busy, pc} !== 9'h000) $display("FAIL rst_exec_no_branch got busy,pc=%h exp 000", {busy, pc}); else n_pass++;
   endtask

   task automatic test_reset_wb();
      mem[0] = enc(4'h1, 1'b1, 4'h7, 4'h1, 4'h2, 15'h0000);
      alu_flags = 4'b0010;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick(); tick();
      reset = 1'b1; #1;
      n_checks++; if (wr_en !== 1'b1) $display("FAIL rst_wb_strobe got %b exp 1", wr_en); else n_pass++;
      tick(); reset = 1'b0;
      n_checks++; if ({wr_en, flags, pc, busy} !== 14'h0) $display("FAIL rst_wb_suppress got wr_en,flags,pc,busy=%h exp 0", {wr_en, flags, pc, busy}); else n_pass++;
   endtask

   task automatic test_reset_priority();
      start = 1'b1; reset = 1'b1;
      tick();
      start = 1'b0; reset = 1'b0;
      n_checks++; if ({busy, mem_rd} !== 2'b00) $display("FAIL rst_priority got busy,mem_rd=%b exp 00", {busy, mem_rd}); else n_pass++;
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_priority_hold got busy=%b exp 0", busy); else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = enc(4'hC, 1'b0, 4'h0, 4'h0, 4'h0, 15'h0);
      mem[8'h00] = enc(4'h0, 1'b0, 4'h1, 4'h2, 4'h3, 15'h0000);
      mem[8'h01] = enc(4'h1, 1'b1, 4'h4, 4'h1, 4'h2, 15'h0123);
      mem[8'h02] = enc(4'hE, 1'b0, 4'h0, 4'h0, 4'h0, 15'h0020);
      mem[8'h20] = enc(4'hB, 1'b0, 4'h0, 4'h5, 4'h6, 15'h0000);
      mem[8'h21] = enc(4'hE, 1'b0, 4'h0, 4'h0, 4'h0, 15'h0030);
      mem[8'h22] = enc(4'hD, 1'b0, 4'h0, 4'h0, 4'h0, 15'h00FF);
      mem[8'hFF] = enc(4'hC, 1'b0, 4'h0, 4'h0, 4'h0, 15'h0000);

      test_reset();
      test_add();
      test_sub_beq();
      test_cmp();
      test_wrap();
      test_halt();
      test_reset_exec();
      test_reset_wb();
      test_reset_priority();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
